ram_arbiter_2p: RTL

//  Shares one ram_32kx16 between two bus masters: the CPU and a DMA/loader port.

---
 rtl/ram_arbiter_2p.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/ram_arbiter_2p.sv
// ram_arbiter_2p
//   Shares one 32Kx16 RAM between a CPU port and a DMA/loader port.
//   One transfer is granted at a time. Each transfer runs IDLE -> ACCESS -> DONE,
//   with WAIT_STATES extra ACCESS cycles. The granted master receives a one-cycle ack
//   and, for reads, its rdata register.
//
// Parameters
//   WAIT_STATES  extra ACCESS cycles per transfer, 0..15
//   RR_PRIORITY  1 = round-robin on contention, 0 = CPU always wins
//
// Ports
//   clk, reset                  system clock, synchronous active-high reset
//   cpu_req/we/byte/addr/wdata  CPU request; req is a level held until cpu_ack
//   cpu_rdata, cpu_ack          CPU read data (holds last read) and completion pulse
//   dma_*                       same set of signals for the DMA port
//   ram_addr, ram_di            registered address and write data to the RAM
//   ram_ce_n, ram_we_n          active-low RAM strobes
//   ram_byte_op                 byte operation; the RAM steers lanes using addr[0]
//   ram_do                      combinational RAM read data
//   busy                        high whenever a transfer is in progress
module ram_arbiter_2p #(
  parameter int unsigned WAIT_STATES = 0,
  parameter bit          RR_PRIORITY = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic        cpu_byte,
  input  logic [15:0] cpu_addr,
  input  logic [15:0] cpu_wdata,
  output logic [15:0] cpu_rdata,
  output logic        cpu_ack,
  input  logic        dma_req,
  input  logic        dma_we,
  input  logic        dma_byte,
  input  logic [15:0] dma_addr,
  input  logic [15:0] dma_wdata,
  output logic [15:0] dma_rdata,
  output logic        dma_ack,
  output logic [15:0] ram_addr,
  output logic [15:0] ram_di,
  output logic        ram_ce_n,
  output logic        ram_we_n,
  output logic        ram_byte_op,
  input  logic [15:0] ram_do,
  output logic        busy
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;
  typedef enum logic {M_CPU, M_DMA} master_t;

  localparam logic [3:0] CNT_INIT = 4'(WAIT_STATES);

  state_t      state;
  master_t     grant;
  master_t     last_grant;
  logic [3:0]  cnt;
  logic        req_we;
  logic        ce_n_q;
  logic        we_n_q;

  master_t     pick;
  logic        pick_valid;
  logic        sel_we;
  logic        sel_byte;
  logic [15:0] sel_addr;
  logic [15:0] sel_wdata;

  // Arbitration and operand selection for the master that would be granted now.
  // NOTE: every signal gets a default at the top of the block so no path leaves
  // it unassigned; that is what keeps always_comb from inferring a latch.
  always_comb begin
    pick_valid = cpu_req | dma_req;
    pick       = M_CPU;
    if (cpu_req && dma_req) begin
      // Round-robin: the master that did not win last time goes first.
      pick = (RR_PRIORITY && (last_grant == M_CPU)) ? M_DMA : M_CPU;
    end else if (dma_req) begin
      pick = M_DMA;
    end

    sel_we    = cpu_we;
    sel_byte  = cpu_byte;
    sel_addr  = cpu_addr;
    sel_wdata = cpu_wdata;
    if (pick == M_DMA) begin
      sel_we    = dma_we;
      sel_byte  = dma_byte;
      sel_addr  = dma_addr;
      sel_wdata = dma_wdata;
    end
  end

  // NOTE: all state here uses non-blocking assignments so every register samples
  // pre-edge values, regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      grant       <= M_CPU;
      last_grant  <= M_DMA;   // the CPU wins the first tie after reset
      cnt         <= '0;
      req_we      <= 1'b0;
      ce_n_q      <= 1'b1;
      we_n_q      <= 1'b1;
      ram_addr    <= '0;
      ram_di      <= '0;
      ram_byte_op <= 1'b0;
      cpu_rdata   <= '0;
      dma_rdata   <= '0;
      cpu_ack     <= 1'b0;
      dma_ack     <= 1'b0;
    end else begin
      cpu_ack <= 1'b0;
      dma_ack <= 1'b0;
      case (state)
        S_IDLE: begin
          ce_n_q <= 1'b1;
          we_n_q <= 1'b1;
          if (pick_valid) begin
            grant       <= pick;
            last_grant  <= pick;
            req_we      <= sel_we;
            ram_addr    <= sel_addr;
            ram_di      <= sel_wdata;
            ram_byte_op <= sel_byte;
            cnt         <= CNT_INIT;
            ce_n_q      <= 1'b0;
            // The write strobe is only ever low in the final ACCESS cycle.
            we_n_q      <= !(sel_we && (CNT_INIT == 4'd0));
            state       <= S_ACCESS;
          end
        end

        S_ACCESS: begin
          if (cnt != 4'd0) begin
            cnt    <= cnt - 4'd1;
            we_n_q <= !(req_we && (cnt == 4'd1));
          end else begin
            ce_n_q <= 1'b1;
            we_n_q <= 1'b1;
            if (!req_we) begin
              if (grant == M_CPU) cpu_rdata <= ram_do;
              else                dma_rdata <= ram_do;
            end
            if (grant == M_CPU) cpu_ack <= 1'b1;
            else                dma_ack <= 1'b1;
            state <= S_DONE;
          end
        end

        S_DONE: begin
          state <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Reset forces the strobes inactive immediately, so a transfer caught by reset
  // can never commit a write on the reset edge.
  assign ram_ce_n = ce_n_q | reset;
  assign ram_we_n = we_n_q | reset;
  assign busy     = (state != S_IDLE);

endmodule
